record_stream_fifo: RTL
=======================

Name: record_stream_fifo

Overview:
- Successor to the word-to-record FIFO. Accepts one WORD_SIZE word per cycle and emits complete RECORD_WORDS-word records.
- Both sides use valid/ready handshakes. The output record is registered, so there is no wide combinational read mux on out_data.
- Adds partial-record abort, flush, an almost-full threshold and occupancy reporting.
- Sits between the byte-stream receiver and the motion-command decoder.

Parameters:
- WORD_SIZE, 8: bits per input word.
- RECORD_WORDS, 16: words per record; power of 2, at least 2.
- SLOTS, 8: record capacity of internal storage; power of 2, at least 2.
- ALMOST_FULL_WORDS, 8: almost_full asserts when free words <= this value; range 0..SLOTS*RECORD_WORDS.
- Derived: RECORD_BITS = WORD_SIZE*RECORD_WORDS; DEPTH = SLOTS*RECORD_WORDS; PW = $clog2(DEPTH).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  word is accepted this cycle.
- in_data  in  WORD_SIZE  input word.
- in_abort  in  1  discard the uncommitted partial record.
- flush  in  1  discard all contents, including the output register.
- out_valid  out  1  out_data holds a complete record.
- out_ready  in  1  consumer takes the record.
- out_data  out  RECORD_BITS  record; word 0 in bits [WORD_SIZE-1:0], word k in bits [(k+1)*WORD_SIZE-1:k*WORD_SIZE].
- used_words  out  PW+1  words in storage, committed plus partial; excludes the output register.
- records  out  PW+1  committed records in storage plus 1 if out_valid.
- almost_full  out  1  (DEPTH - used_words) <= ALMOST_FULL_WORDS.

Behaviour:
- Reset (rst=1 at an edge): write_pos, commit_pos and read_pos go to 0; out_valid=0, out_data=0, used_words=0, records=0. in_ready=1 and almost_full=(DEPTH<=ALMOST_FULL_WORDS) in the cycle after reset.
- Pointers: write_pos, commit_pos and read_pos are PW+1 bits and wrap modulo 2*DEPTH. Storage index is ptr[PW-1:0].
  - used_words = write_pos - read_pos (modular).
  - commit_pos and read_pos always sit on record boundaries.
- Accept:
  - in_ready = !rst && !flush && !in_abort && (used_words != DEPTH).
  - Word is written when in_valid && in_ready: storage[write_pos] <= in_data, write_pos++.
- Commit: when the accepted word makes write_pos - commit_pos reach RECORD_WORDS, commit_pos <= commit_pos + RECORD_WORDS on the same edge.
- Abort: in_abort=1 at an edge sets write_pos <= commit_pos; any in_valid that cycle is ignored (in_ready=0). Committed records and the output register are unaffected. An abort with no partial record pending is a no-op.
- Output register (show-ahead):
  - load = (commit_pos != read_pos) && (!out_valid || out_ready).
  - On load: out_data <= storage words read_pos..read_pos+RECORD_WORDS-1; out_valid <= 1; read_pos <= read_pos + RECORD_WORDS.
  - If out_valid && out_ready && !load: out_valid <= 0; out_data holds its old value.
- Latency: the record-completing word accepted at edge N gives out_valid=1 after edge N+1, when the output register is empty or being drained.
- Throughput: one record per cycle on the output with out_ready=1; one word per cycle on the input.
- Simultaneous events:
  - Accept and load in the same cycle are both performed.
  - A load frees RECORD_WORDS of space visible in in_ready the following cycle; no same-cycle bypass.
  - A write never overwrites unread storage, because of the full check.
- Full: used_words == DEPTH forces in_ready=0. Up to SLOTS+1 records can be buffered, counting the output register.
- Flush: same effect as reset on the next edge. Priority is rst > flush > in_abort > normal operation.
- records and used_words are registered or derived from registers; no combinational path from in_valid or out_ready to either.

Test Plan:
- Reset, then stream 16 words 0x00..0x0F with out_ready=0 → out_valid rises one cycle after the 16th accept; out_data[7:0]=0x00, out_data[127:120]=0x0F; records=1, used_words=0.
- Fill with out_ready=0 → in_ready drops after 8*16+16=144 accepted words (8 in storage plus the output register); used_words=128; almost_full first asserts at used_words=120. Then pulse out_ready for one cycle → in_ready returns the following cycle.
- Write 5 words, pulse in_abort, then write 16 words 0xA0..0xAF → the emitted record is 0xA0..0xAF; records=1; the aborted words never appear.
- Continuous stream of 400 words with out_ready=1 → 25 records in order with correct contents across pointer wrap; in_ready stays 1.
- Mid-record flush with 3 records buffered → after the edge: out_valid=0, records=0, used_words=0; a new record streams in correctly.
- Assert rst while out_valid=1 and a partial record is pending → the same outputs as flush; no stale record is emitted afterwards.

Source files
------------

// File: rtl/record_stream_fifo.sv
// Word-to-record FIFO: packs WORD_SIZE words into RECORD_WORDS-word records behind a registered output.
// Latency: the record-completing word accepted at edge N shows on out_valid after edge N+1 (output empty or draining).
// Backpressure: in_ready drops when storage holds DEPTH words; out_ready stalls the registered record.
module record_stream_fifo #(
  parameter int WORD_SIZE         = 8,
  parameter int RECORD_WORDS      = 16,
  parameter int SLOTS             = 8,
  parameter int ALMOST_FULL_WORDS = 8,
  localparam int RECORD_BITS      = WORD_SIZE * RECORD_WORDS,
  localparam int DEPTH            = SLOTS * RECORD_WORDS,
  localparam int PW               = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_SIZE-1:0]   in_data,
  input  logic                   in_abort,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RECORD_BITS-1:0] out_data,
  output logic [PW:0]            used_words,
  output logic [PW:0]            records,
  output logic                   almost_full
);

  // Shift that turns a word count into a record count.
  localparam int RSH = $clog2(RECORD_WORDS);

  // Pointer-width constants so every compare and add is width-matched.
  localparam logic [PW:0] L_DEPTH = (PW+1)'(DEPTH);
  localparam logic [PW:0] L_REC   = (PW+1)'(RECORD_WORDS);
  localparam logic [PW:0] L_AF    = (PW+1)'(ALMOST_FULL_WORDS);
  localparam logic [PW:0] L_ONE   = (PW+1)'(1);

  // Pointers carry one extra wrap bit so full (DEPTH) and empty (0) are distinct.
  logic [PW:0]            r_wr_pos;
  logic [PW:0]            r_commit_pos;
  logic [PW:0]            r_rd_pos;
  logic                   r_out_valid;
  logic [RECORD_BITS-1:0] r_out_data;
  logic [WORD_SIZE-1:0]   r_mem [DEPTH];

  logic [PW:0]            w_used;
  logic [PW:0]            w_partial;
  logic [PW:0]            w_stored;
  logic [PW-1:0]          w_wr_idx;
  logic [PW-1:0]          w_rd_idx;
  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_commit;
  logic                   w_load;
  logic [RECORD_BITS-1:0] w_rec;

  // Occupancy terms are pure functions of registers, so no input reaches used_words/records.
  assign w_used    = r_wr_pos - r_rd_pos;
  assign w_partial = r_wr_pos - r_commit_pos;
  assign w_stored  = r_commit_pos - r_rd_pos;
  assign w_wr_idx  = r_wr_pos[PW-1:0];
  assign w_rd_idx  = r_rd_pos[PW-1:0];

  // Abort and flush both win over a write in the same cycle, so they also block acceptance.
  assign w_in_ready = !rst && !flush && !in_abort && (w_used != L_DEPTH);
  assign w_accept   = in_valid && w_in_ready;

  // The word that fills the partial record to RECORD_WORDS commits it on the same edge.
  assign w_commit = w_accept && (w_partial == (L_REC - L_ONE));

  // Refill the output register whenever a committed record waits and the slot is free or draining.
  assign w_load = (r_commit_pos != r_rd_pos) && (!r_out_valid || out_ready);

  // Gather the record at read_pos; read_pos is record aligned, so the slice never wraps.
  always_comb begin
    w_rec = '0;
    for (int k = 0; k < RECORD_WORDS; k++) begin
      w_rec[k*WORD_SIZE +: WORD_SIZE] = r_mem[w_rd_idx + PW'(k)];
    end
  end

  // Word storage: written only on an accepted word, never cleared (pointers define validity).
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[w_wr_idx] <= in_data;
    end
  end

  // Pointer update: reset/flush clear, abort rewinds to the last commit, else accept/commit/load advance.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_pos     <= '0;
      r_commit_pos <= '0;
      r_rd_pos     <= '0;
    end else begin
      if (in_abort) begin
        r_wr_pos <= r_commit_pos;
      end else if (w_accept) begin
        r_wr_pos <= r_wr_pos + L_ONE;
        if (w_commit) begin
          r_commit_pos <= r_commit_pos + L_REC;
        end
      end
      if (w_load) begin
        r_rd_pos <= r_rd_pos + L_REC;
      end
    end
  end

  // Show-ahead output register: load a whole record, or go empty when drained with nothing behind it.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_rec;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign used_words  = w_used;
  assign records     = (w_stored >> RSH) + {{PW{1'b0}}, r_out_valid};
  assign almost_full = (L_DEPTH - w_used) <= L_AF;

endmodule
